// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a filtered lock with timeout/retry,
// then releases four domain resets in staged order and re-sequences on lock loss or restart.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic [3:0] dom_rst,
  output logic       ready,
  output logic       restart_ack,
  output logic [3:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       dom_nxt;
  logic [3:0]       retry_nxt;
  logic             ack_nxt;
  logic             locked_p0, locked_s;
  logic             restart_prev;
  logic             restart_edge;

  assign restart_edge = restart_req & ~restart_prev;

  // Input stage: lock synchroniser and restart edge history
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_p0    <= 1'b0;
      locked_s     <= 1'b0;
      restart_prev <= 1'b0;
    end else begin
      locked_p0    <= pll_locked;
      locked_s     <= locked_p0;
      restart_prev <= restart_req;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    dom_nxt   = dom_rst;
    retry_nxt = retry_count;
    ack_nxt   = 1'b0;

    if (restart_edge) begin
      state_nxt = S_RESET_PLL;
      cnt_nxt   = '0;
      dom_nxt   = 4'hF;
      ack_nxt   = 1'b1;
    end else begin
      case (state)
        S_RESET_PLL: begin
          dom_nxt = 4'hF;
          if (cnt == RST_LAST) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
            if (retry_count != 4'hF) retry_nxt = retry_count + 4'd1;
          end
        end
        S_STABLE: begin
          // A glitch here only restarts the lock wait; it is not a retry
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
            dom_nxt   = 4'hE;
          end
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
            dom_nxt   = 4'hF;
          end else if (cnt == GAP_LAST) begin
            // Shifting in zeros keeps the release monotonic in index order
            cnt_nxt = '0;
            dom_nxt = {dom_rst[2:0], 1'b0};
            if (dom_rst == 4'b1000) state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          cnt_nxt = '0;
          dom_nxt = 4'h0;
          if (!locked_s) begin
            state_nxt = S_RESET_PLL;
            dom_nxt   = 4'hF;
          end
        end
        default: begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
          dom_nxt   = 4'hF;
        end
      endcase
    end
  end

  // Sequencer stage: state, counter and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      dom_rst     <= 4'hF;
      ready       <= 1'b0;
      restart_ack <= 1'b0;
      retry_count <= 4'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_rst     <= (state_nxt == S_RESET_PLL);
      dom_rst     <= dom_nxt;
      ready       <= (state_nxt == S_RUN);
      restart_ack <= ack_nxt;
      retry_count <= retry_nxt;
    end
  end

endmodule
